// File: rtl/mmu_pkg.sv
// Shared MMU arbitration definitions: sequencer state encoding and default sizing.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_PORTS_DEFAULT = 3;
  localparam int TIMEOUT_DEFAULT   = 16;

endpackage

// File: rtl/mmu_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mmu_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 any
);

  localparam logic [PW:0] NP_W = (PW+1)'(NUM_PORTS);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set bit overwrites last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= NP_W) sum = sum - NP_W;
      idx = sum[PW-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmu_sel_arbiter.sv
// Round-robin arbiter/sequencer for the MMU selector: grant, drive pulse, wait for free, done.
module mmu_sel_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_free,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_drive,
  output logic [NUM_PORTS-1:0] o_done,
  output logic                 o_timeout,
  output logic                 o_busy,
  output logic                 o_err,
  output state_e               o_dbg_state
);

  // Handshake: a requester holds i_req high until its o_done pulse; the selector sees a
  // one-hot o_select that is stable from the o_drive pulse until o_done, and answers
  // with a single-cycle i_free pulse, which is only legal while the sequencer waits.

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   sel_q, sel_d;
  logic                   drive_q, drive_d;
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   err_q, err_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_PORTS-1:0]   gnt;
  logic                   gnt_any;
  logic [PW-1:0]          grant_idx;

  mmu_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (gnt_any)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i]) grant_idx = PW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    drive_d   = 1'b0;
    done_d    = '0;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q | (i_free && (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          sel_d   = gnt;
          drive_d = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A free arriving on the last counted cycle still wins over the timeout.
        if (i_free) begin
          done_d  = sel_q;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          done_d    = sel_q;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      drive_q   <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      drive_q   <= drive_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_select    = sel_q;
  assign o_drive     = drive_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mmu_sel_arbiter.sv
// Cycle-accurate directed bench for mmu_sel_arbiter: vector table plus hand-written corner sequences.
module tb_mmu_sel_arbiter;
  import mmu_pkg::*;

  logic         clk;
  logic         rstn;
  logic [2:0]   i_req;
  logic         i_free;
  logic [2:0]   o_select;
  logic         o_drive;
  logic [2:0]   o_done;
  logic         o_timeout;
  logic         o_busy;
  logic         o_err;
  state_e       o_dbg_state;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [2:0] req;
    logic       free;
    logic [2:0] sel;
    logic       drv;
    logic [2:0] done;
    logic       to;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  mmu_sel_arbiter #(
    .NUM_PORTS (3),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req       (i_req),
    .i_free      (i_free),
    .o_select    (o_select),
    .o_drive     (o_drive),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] req, input logic free, input logic [2:0] sel,
                              input logic drv, input logic [2:0] done, input logic to,
                              input logic busy, input logic err);
    vec_t v;
    v.req = req; v.free = free; v.sel = sel; v.drv = drv;
    v.done = done; v.to = to; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive this cycle's inputs, check outputs mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input string nm, input vec_t v);
    i_req  = v.req;
    i_free = v.free;
    @(negedge clk);
    chk({nm, ".sel"},   32'(o_select),  32'(v.sel));
    chk({nm, ".drive"}, 32'(o_drive),   32'(v.drv));
    chk({nm, ".done"},  32'(o_done),    32'(v.done));
    chk({nm, ".tmo"},   32'(o_timeout), 32'(v.to));
    chk({nm, ".busy"},  32'(o_busy),    32'(v.busy));
    chk({nm, ".err"},   32'(o_err),     32'(v.err));
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic [2:0] req, input logic [2:0] g);
    vecs.push_back(mk(req, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(req, 1'b0, g,      1'b1, 3'b000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(req, 1'b0, g,      1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(req, 1'b1, g,      1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(req, 1'b0, g,      1'b0, g,      1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Rotation with all requesting and free two cycles after drive, then a lone requester 2.
    push_txn(3'b111, 3'b001);
    push_txn(3'b111, 3'b010);
    push_txn(3'b111, 3'b100);
    push_txn(3'b111, 3'b001);
    vecs.push_back(mk(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(3'b100, 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));

    rstn   = 1'b0;
    i_req  = 3'b111;
    i_free = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.sel",   32'(o_select),  32'h0);
    chk("rst.drive", 32'(o_drive),   32'h0);
    chk("rst.done",  32'(o_done),    32'h0);
    chk("rst.tmo",   32'(o_timeout), 32'h0);
    chk("rst.busy",  32'(o_busy),    32'h0);
    chk("rst.err",   32'(o_err),     32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec%0d", i), vecs[i]);
    end

    // Timeout: requester 0 (pointer wrapped to 0), no free for 16 WAIT cycles.
    cyc("to_idle",  mk(3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    cyc("to_drive", mk(3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 16; k++)
      cyc($sformatf("to_wait%0d", k), mk(3'b001, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    cyc("to_done",  mk(3'b000, 1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0));
    cyc("to_after", mk(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));

    // Free on the last WAIT cycle beats the timeout.
    cyc("lf_idle",  mk(3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    cyc("lf_drive", mk(3'b010, 1'b0, 3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 16; k++)
      cyc($sformatf("lf_wait%0d", k),
          mk(3'b010, (k == 15), 3'b010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    cyc("lf_done",  mk(3'b000, 1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0));
    cyc("lf_after", mk(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));

    // Stray free in IDLE sets a sticky error that survives later transactions.
    cyc("er_pulse", mk(3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    cyc("er_idle",  mk(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
    cyc("er_drive", mk(3'b111, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("er_wait",  mk(3'b111, 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("er_done",  mk(3'b000, 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1));
    cyc("er_after", mk(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
    cyc("g0_idle",  mk(3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
    cyc("g0_drive", mk(3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("g0_wait",  mk(3'b001, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("g0_done",  mk(3'b000, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1));

    // Reset mid-WAIT for requester 1 (pointer is 1 here), then pointer must restart at 0.
    cyc("rw_idle",  mk(3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
    cyc("rw_drive", mk(3'b010, 1'b0, 3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("rw_wait0", mk(3'b010, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1));
    cyc("rw_wait1", mk(3'b010, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1));
    rstn = 1'b0;
    cyc("rw_rst0",  mk(3'b010, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    cyc("rw_rst1",  mk(3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    rstn = 1'b1;
    cyc("rr_idle",  mk(3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    cyc("rr_drive", mk(3'b011, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0));
    cyc("rr_wait",  mk(3'b011, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));
    cyc("rr_done",  mk(3'b000, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0));
    cyc("rr_after", mk(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_sel_arbiter.md
# mmu_sel_arbiter

Synchronous round-robin arbiter and sequencer for the MMU's three-way selector stage. It collects requests from up to `NUM_PORTS` MMU requesters and grants one at a time. For the granted requester it drives a stable one-hot select and a single drive pulse into the selector, then waits for the selector's free indication. It returns a per-requester done pulse, with a timeout guard against a stalled handshake.

## Interface
- `NUM_PORTS`, default 3: number of requesters; width of select/request/done vectors.
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before forced completion (must be ≥ 2).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `i_req`, input, NUM_PORTS: level request per requester; held until the matching `o_done` bit.
- `i_free`, input, 1: one-cycle pulse, synchronous to `clk`; selector transfer complete.
- `o_select`, output, NUM_PORTS: registered one-hot select to selector; all-zero when idle.
- `o_drive`, output, 1: registered one-cycle drive pulse to selector.
- `o_done`, output, NUM_PORTS: registered one-cycle completion pulse to granted requester.
- `o_timeout`, output, 1: registered one-cycle pulse, coincident with `o_done`, when completion was forced.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_err`, output, 1: sticky; set by `i_free` outside WAIT; cleared only by reset.

## Operation
- States: IDLE, DRIVE, WAIT, DONE.
- IDLE: if `i_req != 0`, round-robin pick → register one-hot grant into `o_select` → DRIVE. Otherwise stay in IDLE.
- DRIVE: `o_drive=1` for exactly this cycle. Clear the wait counter → WAIT.
- WAIT: `o_drive=0`, `o_select` held.
  - `i_free=1` → DONE.
  - Otherwise increment the counter; when the counter reaches `TIMEOUT-1` with no free → DONE with timeout flag set.
  - `i_free` on the final cycle takes priority over timeout: no timeout flag.
- DONE: `o_done = o_select` for one cycle; `o_timeout` = timeout flag. Update pointer to grant index + 1, wrapping NUM_PORTS-1 → 0. Clear `o_select` → IDLE.
- Round-robin rule: search starts at the pointer and ascends with wrap; first set bit wins.
- Pointer reset value is 0, so index 0 has first priority after reset.
- A requester dropping `i_req` after grant is ignored; the transaction completes normally.
- A requester dropping `i_req` before grant is simply not considered.
- `i_free` in IDLE, DRIVE or DONE: ignored for state; sets `o_err`.
- Counter width: `$clog2(TIMEOUT)`; saturates at no wrap risk since exit occurs at `TIMEOUT-1`.
- Reset at any point, including mid-WAIT: state goes to IDLE and outstanding grant is abandoned with no `o_done`.
  - Pointer=0, counter=0.
  - Outputs `o_select=0`, `o_drive=0`, `o_done=0`, `o_timeout=0`, `o_busy=0`, `o_err=0`.

## Timing
- Request sampled in IDLE at edge t → `o_select` valid and `o_drive=1` in cycle t+1.
- `i_free` sampled high at edge u (in WAIT) → `o_done` pulse in cycle u+1. `o_select` returns to 0 in cycle u+2.
- Minimum transaction, request to done: 4 cycles (IDLE, DRIVE, WAIT with immediate free, DONE).
- Back-to-back: a new grant is issued no earlier than the cycle after DONE (IDLE arbitration cycle). Issue rate is at most one transaction per 4 cycles.
- Timeout: `o_done`/`o_timeout` are asserted exactly `TIMEOUT` cycles after the first WAIT cycle.
- `o_select` is stable and one-hot for the whole DRIVE..DONE window. Downstream selectors rely on this.

## Structure
- Shared package `mmu_pkg`: state encodings (2-bit: IDLE=0, DRIVE=1, WAIT=2, DONE=3) and the default TIMEOUT constant.
- Sub-module `mmu_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and pointer.
  - Outputs: one-hot grant and `any` flag.
  - Reusable by other MMU arbiters.
- Top module holds FSM, pointer, wait counter, output registers, sticky error.

## Test plan
- Reset with `i_req=3'b111` held → all outputs 0. After release: grant order 0, 1, 2, 0 with `i_free` two cycles after each `o_drive`. `o_done` = 001, 010, 100, 001.
- Single request `i_req=3'b100`, free in first WAIT cycle → `o_drive` at t+1, `o_done=3'b100` at t+3, `o_busy` high t+1..t+3.
- No `i_free`, TIMEOUT=16 → `o_done` and `o_timeout` pulse exactly 16 cycles after WAIT entry, then IDLE.
- `i_free` on WAIT cycle 15 (TIMEOUT=16) → `o_done=1`, `o_timeout=0`.
- `i_free` pulsed in IDLE → `o_err=1` stays high through later transactions until `rstn` low.
- `rstn` asserted mid-WAIT for requester 1 → immediate outputs 0, no `o_done`. After release with `i_req=3'b011`, requester 0 is granted first (pointer reset).
